// File: rtl/inst_prefetch_pkg.sv
// inst_prefetch shared definitions: FIFO geometry, FSM states,
// reset/chip-enable levels and the fetch bundle carried through the FIFO.
package inst_prefetch_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = 2;

  localparam logic [FIFO_AW:0] FIFO_FULL = 3'd4;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic RST_ENABLE   = 1'b1;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;

  function automatic logic [FIFO_AW:0] next_count(
    input logic [FIFO_AW:0] cnt,
    input logic             push,
    input logic             pop
  );
    return cnt + {2'b00, push} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/inst_prefetch_if.sv
// inst_prefetch bus: ROM fetch port plus the ID-side handshake.
// master = prefetch unit, slave = ROM/decode environment.
interface inst_prefetch_if;

  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic [31:0] inst_i;
  logic        inst_ce_o;
  logic [31:0] inst_addr_o;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;

  modport master (
    input  stall_i,
    input  branch_flag_i,
    input  branch_target_i,
    input  inst_i,
    output inst_ce_o,
    output inst_addr_o,
    output id_valid_o,
    output id_pc_o,
    output id_inst_o
  );

  modport slave (
    output stall_i,
    output branch_flag_i,
    output branch_target_i,
    output inst_i,
    input  inst_ce_o,
    input  inst_addr_o,
    input  id_valid_o,
    input  id_pc_o,
    input  id_inst_o
  );

endinterface

// File: rtl/inst_prefetch_fifo.sv
// prefetch_fifo: 4-entry {pc, inst} queue with flush that can
// optionally keep one survivor (the head, or the word pushed this cycle).
module prefetch_fifo
  import inst_prefetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic             keep_head,
  input  fetch_t           wdata,
  output fetch_t           head,
  output logic [FIFO_AW:0] count
);

  fetch_t             mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW-1:0] wr_ptr;
  logic               push_ok;
  logic               pop_ok;
  logic               empty;

  assign empty   = (count == '0);
  assign push_ok = push && (count != FIFO_FULL);
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write; the slot at wr_ptr never aliases a kept head.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer/occupancy bookkeeping, flush outranks push/pop.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      if (keep_head && !empty && !pop_ok) begin
        wr_ptr <= rd_ptr + 2'd1;
        count  <= 3'd1;
      end else if (keep_head && empty && push_ok) begin
        wr_ptr <= wr_ptr + 2'd1;
        count  <= 3'd1;
      end else begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      count <= next_count(count, push_ok, pop_ok);
    end
  end

endmodule

// File: rtl/inst_prefetch.sv
// inst_prefetch: fetch FSM + PC in front of a 4-deep prefetch FIFO.
// Build macro DELAY_SLOT_EN keeps the branch delay-slot word on redirect.
module inst_prefetch
  import inst_prefetch_pkg::*;
(
  input logic             clk,
  input logic             rst,
  inst_prefetch_if.master bus
);

  state_t           state;
  logic [31:0]      pc;
  logic             ce;
  logic             push;
  logic             pop;
  logic             keep_head;
  logic             head_valid;
  logic [FIFO_AW:0] count;
  logic [FIFO_AW:0] count_nxt;
  fetch_t           head;
  fetch_t           wdata;

`ifdef DELAY_SLOT_EN
  assign keep_head = 1'b1;
`else
  assign keep_head = 1'b0;
`endif

  assign push       = (ce == CHIP_ENABLE);
  assign head_valid = (count != '0);
  assign pop        = head_valid && !bus.stall_i;
  assign count_nxt  = next_count(count, push, pop);
  assign wdata      = '{pc: pc, inst: bus.inst_i};

  prefetch_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (bus.branch_flag_i),
    .keep_head (keep_head),
    .wdata     (wdata),
    .head      (head),
    .count     (count)
  );

  // Fetch FSM with registered chip enable; branch redirects from any state.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state <= ST_BOOT;
      ce    <= CHIP_DISABLE;
      pc    <= ZERO_WORD;
    end else if (bus.branch_flag_i) begin
      state <= ST_RUN;
      ce    <= CHIP_ENABLE;
      pc    <= bus.branch_target_i;
    end else begin
      unique case (state)
        ST_BOOT: begin
          state <= ST_RUN;
          ce    <= CHIP_ENABLE;
        end
        ST_RUN: begin
          pc <= pc + PC_STEP;
          if (count_nxt == FIFO_FULL) begin
            state <= ST_HOLD;
            ce    <= CHIP_DISABLE;
          end
        end
        ST_HOLD: begin
          if (pop) begin
            state <= ST_RUN;
            ce    <= CHIP_ENABLE;
          end
        end
        default: begin
          state <= ST_BOOT;
          ce    <= CHIP_DISABLE;
        end
      endcase
    end
  end

  assign bus.inst_ce_o   = ce;
  assign bus.inst_addr_o = pc;
  assign bus.id_valid_o  = head_valid;
  assign bus.id_pc_o     = head_valid ? head.pc : ZERO_WORD;
  assign bus.id_inst_o   = head_valid ? head.inst : ZERO_WORD;

endmodule

// File: tb/tb_inst_prefetch.sv
// tb_inst_prefetch: directed vectors, expected ID pops queued up front
// and checked by a negedge monitor whenever the DUT pops.
module tb_inst_prefetch;
  import inst_prefetch_pkg::*;

`ifdef DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_prefetch_if bus();

  inst_prefetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ROM: word n holds n
  assign bus.inst_i = {2'b00, bus.inst_addr_o[31:2]};

  int          checks = 0;
  int          passed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ce"}, {31'b0, bus.inst_ce_o}, 32'd0);
    chk({tag, "_addr"}, bus.inst_addr_o, 32'h0);
    chk({tag, "_valid"}, {31'b0, bus.id_valid_o}, 32'd0);
    chk({tag, "_pc"}, bus.id_pc_o, 32'h0);
    chk({tag, "_inst"}, bus.id_inst_o, 32'h0);
  endtask

  // Scoreboard monitor: every pop must match the next queued PC.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.id_valid_o === 1'b1 && bus.stall_i === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL pop_unexpected: got pc %h want none", bus.id_pc_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_pc", bus.id_pc_o, mon_e);
        chk("pop_inst", bus.id_inst_o, mon_e >> 2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.stall_i         = 1'b1;
    bus.branch_flag_i   = 1'b0;
    bus.branch_target_i = 32'h0;

    // Reset, then fill with stall held: 4 pushes then HOLD
    repeat (3) tick();
    at_neg();
    chk_reset("rst0");
    tick();
    rst = 1'b0;
    at_neg();
    chk("boot_ce", {31'b0, bus.inst_ce_o}, 32'd0);
    tick();
    at_neg();
    chk("a_ce_run", {31'b0, bus.inst_ce_o}, 32'd1);
    chk("a_addr0", bus.inst_addr_o, 32'h0);
    tick();
    at_neg();
    chk("a_addr4", bus.inst_addr_o, 32'h4);
    tick();
    tick();
    at_neg();
    chk("a_addrC", bus.inst_addr_o, 32'hC);
    tick();
    at_neg();
    chk("a_hold_ce", {31'b0, bus.inst_ce_o}, 32'd0);
    chk("a_hold_addr", bus.inst_addr_o, 32'h10);
    chk("a_hold_valid", {31'b0, bus.id_valid_o}, 32'd1);
    chk("a_hold_pc", bus.id_pc_o, 32'h0);
    tick();
    exp_q.push_back(32'h0);
    bus.stall_i = 1'b0;
    at_neg();
    chk("a_hold2_ce", {31'b0, bus.inst_ce_o}, 32'd0);
    chk("a_hold2_addr", bus.inst_addr_o, 32'h10);
    tick();
    bus.stall_i = 1'b1;
    at_neg();
    chk("a_resume_ce", {31'b0, bus.inst_ce_o}, 32'd1);
    chk("a_resume_addr", bus.inst_addr_o, 32'h10);
    chk("a_resume_pc", bus.id_pc_o, 32'h4);

    // Branch to 0x100 with FIFO {0x8,0xC} and stall held
    tick();
    rst = 1'b1;
    bus.stall_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    tick();
    tick();
    tick();
    tick();
    bus.stall_i = 1'b1;
    tick();
    bus.branch_flag_i   = 1'b1;
    bus.branch_target_i = 32'h100;
    tick();
    bus.branch_flag_i = 1'b0;
    bus.stall_i       = 1'b0;
    if (DS) exp_q.push_back(32'h8);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    at_neg();
    chk("b_addr", bus.inst_addr_o, 32'h100);
    chk("b_ce", {31'b0, bus.inst_ce_o}, 32'd1);
    chk("b_valid", {31'b0, bus.id_valid_o}, {31'b0, DS});
    chk("b_pc", bus.id_pc_o, DS ? 32'h8 : 32'h0);
    tick();
    tick();
    tick();
    bus.stall_i = 1'b1;
    at_neg();
    chk("b_head108", bus.id_pc_o, 32'h108);

    // Branch with empty FIFO at fetch PC 0x20, then reset mid-HOLD
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.branch_flag_i   = 1'b1;
    bus.branch_target_i = 32'h20;
    tick();
    bus.branch_target_i = 32'h40;
    at_neg();
    chk("c_addr20", bus.inst_addr_o, 32'h20);
    chk("c_empty", {31'b0, bus.id_valid_o}, 32'd0);
    tick();
    bus.branch_flag_i = 1'b0;
    at_neg();
    chk("c_addr40", bus.inst_addr_o, 32'h40);
    chk("c_valid", {31'b0, bus.id_valid_o}, {31'b0, DS});
    chk("c_pc", bus.id_pc_o, DS ? 32'h20 : 32'h0);
    chk("c_inst", bus.id_inst_o, DS ? 32'h8 : 32'h0);
    repeat (4) tick();
    at_neg();
    chk("c_hold_ce", {31'b0, bus.inst_ce_o}, 32'd0);
    chk("c_hold_addr", bus.inst_addr_o, DS ? 32'h4C : 32'h50);
    tick();
    rst = 1'b1;
    bus.branch_flag_i   = 1'b1;
    bus.branch_target_i = 32'h200;
    bus.stall_i         = 1'b0;
    tick();
    bus.branch_flag_i = 1'b0;
    at_neg();
    chk_reset("rst_mid");

    // PC wrap through 0xFFFFFFFC
    tick();
    rst = 1'b0;
    bus.branch_flag_i   = 1'b1;
    bus.branch_target_i = 32'hFFFF_FFF8;
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    tick();
    bus.branch_flag_i = 1'b0;
    at_neg();
    chk("d_addrF8", bus.inst_addr_o, 32'hFFFF_FFF8);
    tick();
    at_neg();
    chk("d_addrFC", bus.inst_addr_o, 32'hFFFF_FFFC);
    tick();
    at_neg();
    chk("d_addr0", bus.inst_addr_o, 32'h0);
    tick();
    bus.stall_i = 1'b1;
    at_neg();
    chk("d_head0", bus.id_pc_o, 32'h0);
    chk("d_addr4", bus.inst_addr_o, 32'h4);
    tick();
    at_neg();
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/inst_prefetch.md
INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  synchronous, active-high reset (`RstEnable).
REQ-003 SHALL have port stall_i  in  1  decode stall from ctrl; 1 = ID does not accept this cycle.
REQ-004 SHALL have port branch_flag_i  in  1  redirect request from ID, single-cycle pulse.
REQ-005 SHALL have port branch_target_i  in  32  redirect address, word aligned.
REQ-006 SHALL have port inst_i  in  32  instruction word from combinational instruction ROM, valid in the same cycle as inst_addr_o.
REQ-007 SHALL have port inst_ce_o  out  1  ROM chip enable (`ChipEnable/`ChipDisable).
REQ-008 SHALL have port inst_addr_o  out  32  fetch PC driven to ROM.
REQ-009 SHALL have port id_valid_o  out  1  head entry valid toward IF/ID.
REQ-010 SHALL have port id_pc_o  out  32  PC of head entry, `ZeroWord when invalid.
REQ-011 SHALL have port id_inst_o  out  32  instruction of head entry, `ZeroWord when invalid.

Function
REQ-012 SHALL hold a 4-entry FIFO of {pc, inst} pairs, 3-bit occupancy count 0..4, 2-bit wrapping read/write pointers.
REQ-013 SHALL run FSM BOOT -> RUN <-> HOLD; BOOT lasts exactly one cycle after rst deasserts with inst_ce_o=0.
REQ-014 In RUN, inst_ce_o SHALL be 1; push {inst_addr_o, inst_i} at edge and advance fetch PC by 4 (mod 2^32).
REQ-015 SHALL enter HOLD when occupancy after this cycle's push/pop equals 4; in HOLD inst_ce_o=0, PC frozen, no push.
REQ-016 SHALL leave HOLD to RUN on the edge where a pop occurs.
REQ-017 Pop SHALL occur when id_valid_o=1 and stall_i=0; head outputs are combinational from FIFO head.
REQ-018 Simultaneous push and pop SHALL leave occupancy unchanged; push to full never occurs.
REQ-019 On branch_flag_i=1 the fetch PC SHALL load branch_target_i at the edge and the FSM SHALL go to RUN regardless of current state.
REQ-020 Branch SHALL take priority over normal push/pop bookkeeping per Configuration rules; FIFO content after branch SHALL contain only entries permitted there.
REQ-021 First target fetch SHALL appear on inst_addr_o in the cycle after branch_flag_i (one-cycle redirect latency).
REQ-022 PC wrap from 0xFFFFFFFC SHALL yield 0x00000000 without error.

Reset
REQ-023 While rst=1: fetch PC=0x00000000, occupancy=0, pointers=0, state=BOOT, inst_ce_o=0, id_valid_o=0, id_pc_o=id_inst_o=`ZeroWord.
REQ-024 rst asserted mid-operation SHALL discard all FIFO entries at that edge, overriding branch and pop.

Configuration
REQ-025 Macro DELAY_SLOT_EN SHALL select MIPS delay-slot retention.
REQ-026 With DELAY_SLOT_EN: on branch the oldest not-yet-consumed instruction after the branch survives -- the head if FIFO non-empty, else the word fetched this cycle (pushed); if that survivor is popped this cycle FIFO ends empty; all other entries discarded.
REQ-027 Without DELAY_SLOT_EN: on branch FIFO SHALL be emptied entirely and this cycle's fetch discarded; a pop this cycle still completes.

Structure
REQ-028 Shared defines file SHALL hold FIFO depth (4), its log2 (2), FSM state encodings, and reuse `ZeroWord, `ChipEnable, `ChipDisable, `RstEnable.
REQ-029 The FIFO SHALL be a sub-module named prefetch_fifo (push, pop, flush, keep_head, count); FSM and PC logic stay in inst_prefetch.

Verification
REQ-030 Reset release, stall_i=0, ROM word n = n: inst_addr_o 0x0,0x4,0x8...; id_pc_o 0x0 first valid on the cycle after BOOT+1 push, then one per cycle.
REQ-031 stall_i held 1 from reset: exactly 4 pushes (PCs 0x0..0xC), then inst_ce_o=0, state HOLD; release stall -> id_pc_o 0x0, fetch resumes at 0x10 next cycle.
REQ-032 Branch to 0x100 with FIFO {0x8,0xC}, stall_i=1, DELAY_SLOT_EN defined: FIFO holds only 0x8; next fetch 0x100; ID sequence 0x8, 0x100, 0x104.
REQ-033 Same as REQ-032 without DELAY_SLOT_EN: FIFO empty; ID sequence 0x100, 0x104.
REQ-034 Branch with FIFO empty, fetch PC 0x20, DELAY_SLOT_EN: 0x20 pushed and retained, next fetch target; rst mid-HOLD -> all outputs at REQ-023 values next cycle.
REQ-035 Start PC forced via branch to 0xFFFFFFF8: fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
